// File: rtl/traffic_intersection.sv
// Multi-approach intersection controller: serves NUM_DIR signal heads in rotation with all-red clearance.
// Optional DEMAND_SKIP_EN: serve only directions whose vehicle demand has been latched.
module traffic_intersection #(
  parameter int NUM_DIR              = 4,
  parameter int CLK_FREQ_HZ          = 2000,
  parameter int BLINK_HALF_PERIOD_MS = 1,
  parameter int BLINK_GREEN_TICKS    = 3,
  parameter int RED_YELLOW_MS        = 1,
  parameter int ALL_RED_MS           = 2,
  parameter int GREEN_MS_DEF         = 5,
  parameter int YELLOW_MS_DEF        = 2
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic [2:0]                 cmd_type_i,
  input  logic                       cmd_val_i,
  input  logic [$clog2(NUM_DIR)-1:0] cmd_addr_i,
  input  logic [15:0]                cmd_data_i,
  input  logic [NUM_DIR-1:0]         demand_i,
  output logic [NUM_DIR-1:0]         red_o,
  output logic [NUM_DIR-1:0]         yellow_o,
  output logic [NUM_DIR-1:0]         green_o,
  output logic [$clog2(NUM_DIR)-1:0] dir_o,
  output logic [2:0]                 state_o
);

  localparam int DW = $clog2(NUM_DIR);
  localparam int CW = DW + 1;

  localparam logic [2:0] ST_OFF          = 3'd0;
  localparam logic [2:0] ST_YELLOW_BLINK = 3'd1;
  localparam logic [2:0] ST_ALL_RED      = 3'd2;
  localparam logic [2:0] ST_RED_YELLOW   = 3'd3;
  localparam logic [2:0] ST_GREEN        = 3'd4;
  localparam logic [2:0] ST_GREEN_BLINK  = 3'd5;
  localparam logic [2:0] ST_YELLOW       = 3'd6;

  localparam logic [2:0] CMD_START      = 3'd0;
  localparam logic [2:0] CMD_OFF        = 3'd1;
  localparam logic [2:0] CMD_BLINK      = 3'd2;
  localparam logic [2:0] CMD_SET_GREEN  = 3'd3;
  localparam logic [2:0] CMD_SET_YELLOW = 3'd5;

  function automatic int ms_to_clk_const(input int ms);
    int c;
    c = (ms * CLK_FREQ_HZ) / 1000;
    if (c < 1) c = 1;
    return c;
  endfunction

  function automatic int sat16(input int c);
    return (c > 65535) ? 65535 : c;
  endfunction

  localparam int ALL_RED_CLK     = ms_to_clk_const(ALL_RED_MS);
  localparam int RED_YELLOW_CLK  = ms_to_clk_const(RED_YELLOW_MS);
  localparam int BLINK_HALF_CLK  = ms_to_clk_const(BLINK_HALF_PERIOD_MS);
  localparam int GREEN_BLINK_CLK = 2 * BLINK_HALF_CLK * BLINK_GREEN_TICKS;

  localparam logic [31:0] ALL_RED_DUR     = 32'(ALL_RED_CLK);
  localparam logic [31:0] RED_YELLOW_DUR  = 32'(RED_YELLOW_CLK);
  localparam logic [31:0] GREEN_BLINK_DUR = 32'(GREEN_BLINK_CLK);
  localparam logic [31:0] BLINK_HALF_DUR  = 32'(BLINK_HALF_CLK);
  localparam logic [31:0] BLINK_PER_DUR   = 32'(2 * BLINK_HALF_CLK);
  localparam logic [31:0] FREQ32          = 32'(CLK_FREQ_HZ);
  localparam logic [15:0] GREEN_DEF_CLK   = 16'(sat16(ms_to_clk_const(GREEN_MS_DEF)));
  localparam logic [15:0] YELLOW_DEF_CLK  = 16'(sat16(ms_to_clk_const(YELLOW_MS_DEF)));
  localparam logic [DW-1:0] DIR_LAST      = DW'(NUM_DIR - 1);

  // Host time in ms -> clocks, saturated to 16 bits; zero would stall a phase so it becomes 1.
  function automatic logic [15:0] cmd_to_clk(input logic [15:0] ms);
    logic [31:0] prod;
    prod = ({16'd0, ms} * FREQ32) / 32'd1000;
    if (prod > 32'd65535) return 16'hFFFF;
    else if (prod == 32'd0) return 16'd1;
    else return prod[15:0];
  endfunction

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] dir_q, dir_d;
  logic [31:0]   timer_q;
  logic [31:0]   blink_q;
  logic [31:0]   cur_dur;
  logic          timer_done;
  logic          restart;
  logic          blink_on;
  logic [15:0]   green_time_q  [NUM_DIR];
  logic [15:0]   yellow_time_q [NUM_DIR];

  logic          cmd_start, cmd_off, cmd_blink;
  logic          addr_ok, set_green, set_yellow;
  logic [31:0]   addr_ext;
  logic [NUM_DIR-1:0] dir_oh;

  assign cmd_start = cmd_val_i && (cmd_type_i == CMD_START);
  assign cmd_off   = cmd_val_i && (cmd_type_i == CMD_OFF);
  assign cmd_blink = cmd_val_i && (cmd_type_i == CMD_BLINK);

  assign addr_ext   = 32'(cmd_addr_i);
  assign addr_ok    = addr_ext < 32'(NUM_DIR);
  assign set_green  = cmd_val_i && (cmd_type_i == CMD_SET_GREEN)
                      && (state_q == ST_YELLOW_BLINK) && addr_ok;
  assign set_yellow = cmd_val_i && (cmd_type_i == CMD_SET_YELLOW)
                      && (state_q == ST_YELLOW_BLINK) && addr_ok;

  assign dir_oh = NUM_DIR'(1) << dir_q;

`ifdef DEMAND_SKIP_EN
  logic [NUM_DIR-1:0] pend_q;
  logic [NUM_DIR-1:0] green_clr;
  logic               start_hold_q;
  logic               pend_found;
  logic [DW-1:0]      pend_dir;
  logic [CW-1:0]      cand;

  // dir already points at d+1 during clearance, so the cyclic search starts at dir itself.
  always_comb begin
    pend_found = 1'b0;
    pend_dir   = dir_q;
    cand       = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      cand = {1'b0, dir_q} + CW'(i);
      if (cand >= CW'(NUM_DIR)) cand = cand - CW'(NUM_DIR);
      if (!pend_found && pend_q[cand[DW-1:0]]) begin
        pend_found = 1'b1;
        pend_dir   = cand[DW-1:0];
      end
    end
  end

  assign green_clr = ((state_d == ST_GREEN) && (state_q != ST_GREEN)) ? dir_oh : '0;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pend_q       <= '0;
      start_hold_q <= 1'b0;
    end else if (cmd_start) begin
      pend_q       <= '0;
      start_hold_q <= 1'b1;
    end else begin
      pend_q <= (pend_q | demand_i) & ~green_clr;
      if (state_d != ST_ALL_RED) start_hold_q <= 1'b0;
    end
  end
`else
  logic unused_demand;
  assign unused_demand = ^demand_i;
`endif

  always_comb begin
    case (state_q)
      ST_ALL_RED:     cur_dur = ALL_RED_DUR;
      ST_RED_YELLOW:  cur_dur = RED_YELLOW_DUR;
      ST_GREEN:       cur_dur = {16'd0, green_time_q[dir_q]};
      ST_GREEN_BLINK: cur_dur = GREEN_BLINK_DUR;
      ST_YELLOW:      cur_dur = {16'd0, yellow_time_q[dir_q]};
      default:        cur_dur = 32'd1;
    endcase
  end

  assign timer_done = (timer_q >= (cur_dur - 32'd1));

  // Commands win over timer expiry; start/off/blink also restart the timer and blink phase.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    restart = 1'b0;
    if (cmd_start) begin
      state_d = ST_ALL_RED;
      dir_d   = '0;
      restart = 1'b1;
    end else if (cmd_off) begin
      state_d = ST_OFF;
      restart = 1'b1;
    end else if (cmd_blink) begin
      state_d = ST_YELLOW_BLINK;
      restart = 1'b1;
    end else if (timer_done) begin
      case (state_q)
        ST_ALL_RED: begin
`ifdef DEMAND_SKIP_EN
          if (start_hold_q) begin
            state_d = ST_RED_YELLOW;
          end else if (pend_found) begin
            state_d = ST_RED_YELLOW;
            dir_d   = pend_dir;
          end
`else
          state_d = ST_RED_YELLOW;
`endif
        end
        ST_RED_YELLOW:  state_d = ST_GREEN;
        ST_GREEN:       state_d = ST_GREEN_BLINK;
        ST_GREEN_BLINK: state_d = ST_YELLOW;
        ST_YELLOW: begin
          state_d = ST_ALL_RED;
          dir_d   = (dir_q == DIR_LAST) ? '0 : dir_q + DW'(1);
        end
        default: ;
      endcase
    end
    if (state_d != state_q) restart = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= ST_OFF;
      dir_q   <= '0;
      timer_q <= '0;
      blink_q <= '0;
      for (int i = 0; i < NUM_DIR; i++) begin
        green_time_q[i]  <= GREEN_DEF_CLK;
        yellow_time_q[i] <= YELLOW_DEF_CLK;
      end
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      if (restart) begin
        timer_q <= '0;
        blink_q <= '0;
      end else begin
        if (!timer_done) timer_q <= timer_q + 32'd1;
        blink_q <= (blink_q >= BLINK_PER_DUR - 32'd1) ? '0 : blink_q + 32'd1;
      end
      if (set_green)  green_time_q[cmd_addr_i]  <= cmd_to_clk(cmd_data_i);
      if (set_yellow) yellow_time_q[cmd_addr_i] <= cmd_to_clk(cmd_data_i);
    end
  end

  // Blink phase starts dark on entry to a blink state.
  assign blink_on = (blink_q >= BLINK_HALF_DUR);

  always_comb begin
    red_o    = '0;
    yellow_o = '0;
    green_o  = '0;
    case (state_q)
      ST_YELLOW_BLINK: yellow_o = blink_on ? '1 : '0;
      ST_ALL_RED:      red_o    = '1;
      ST_RED_YELLOW: begin
        red_o    = '1;
        yellow_o = dir_oh;
      end
      ST_GREEN: begin
        red_o   = ~dir_oh;
        green_o = dir_oh;
      end
      ST_GREEN_BLINK: begin
        red_o   = ~dir_oh;
        green_o = blink_on ? dir_oh : '0;
      end
      ST_YELLOW: begin
        red_o    = ~dir_oh;
        yellow_o = dir_oh;
      end
      default: ;
    endcase
  end

  assign dir_o   = dir_q;
  assign state_o = state_q;

  a_single_mover: assert property (@(posedge clk_i) disable iff (srst_i)
    (state_q != ST_YELLOW_BLINK) |-> $onehot0(yellow_o | green_o));
  a_single_green: assert property (@(posedge clk_i) disable iff (srst_i)
    $onehot0(green_o));

endmodule

// File: tb/tb_traffic_intersection.sv
// Directed bench for traffic_intersection: 3 approaches, 4clk all-red, 2clk red-yellow, 10/4clk green/yellow.
module tb_traffic_intersection;

  localparam logic [2:0] S_OFF = 3'd0;
  localparam logic [2:0] S_YB  = 3'd1;
  localparam logic [2:0] S_AR  = 3'd2;
  localparam logic [2:0] S_RY  = 3'd3;
  localparam logic [2:0] S_G   = 3'd4;
  localparam logic [2:0] S_GB  = 3'd5;
  localparam logic [2:0] S_Y   = 3'd6;

  localparam logic [2:0] C_START = 3'd0;
  localparam logic [2:0] C_OFF   = 3'd1;
  localparam logic [2:0] C_BLINK = 3'd2;
  localparam logic [2:0] C_SET_G = 3'd3;
  localparam logic [2:0] C_SET_Y = 3'd5;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic [2:0]  cmd_type_i;
  logic        cmd_val_i;
  logic [1:0]  cmd_addr_i;
  logic [15:0] cmd_data_i;
  logic [2:0]  demand_i;
  logic [2:0]  red_o, yellow_o, green_o;
  logic [1:0]  dir_o;
  logic [2:0]  state_o;

  always #5 clk_i = ~clk_i;

  traffic_intersection #(
    .NUM_DIR(3), .CLK_FREQ_HZ(2000), .BLINK_HALF_PERIOD_MS(1), .BLINK_GREEN_TICKS(2),
    .RED_YELLOW_MS(1), .ALL_RED_MS(2), .GREEN_MS_DEF(5), .YELLOW_MS_DEF(2)
  ) dut (
    .clk_i(clk_i), .srst_i(srst_i), .cmd_type_i(cmd_type_i), .cmd_val_i(cmd_val_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .demand_i(demand_i),
    .red_o(red_o), .yellow_o(yellow_o), .green_o(green_o), .dir_o(dir_o), .state_o(state_o)
  );

  int vectors = 0;
  int errors  = 0;
  int len, bad;
  logic [2:0] pst [5];
  int plen [5];

  // Expected {red, yellow, green} for a state, served direction and cycle index within the phase.
  function automatic logic [8:0] exp_lamps(input logic [2:0] st, input logic [1:0] d, input int k);
    logic [2:0] oh, r, y, g;
    logic on;
    oh = 3'b001 << d;
    on = ((k / 2) % 2) == 1;
    r = 3'b000; y = 3'b000; g = 3'b000;
    case (st)
      S_YB: y = on ? 3'b111 : 3'b000;
      S_AR: r = 3'b111;
      S_RY: begin r = 3'b111; y = oh; end
      S_G:  begin r = ~oh; g = oh; end
      S_GB: begin r = ~oh; g = on ? oh : 3'b000; end
      S_Y:  begin r = ~oh; y = oh; end
      default: ;
    endcase
    return {r, y, g};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [2:0] t, input logic [1:0] a, input logic [15:0] d);
    cmd_type_i = t; cmd_addr_i = a; cmd_data_i = d; cmd_val_i = 1'b1;
    step();
    cmd_val_i = 1'b0;
  endtask

  task automatic do_reset();
    srst_i = 1'b1; cmd_val_i = 1'b0; cmd_type_i = 3'd0; cmd_addr_i = 2'd0;
    cmd_data_i = 16'd0; demand_i = 3'b111;
    step(); step();
    srst_i = 1'b0;
  endtask

  // Follows one phase: counts cycles spent in st (bounded by maxc) and lamp/dir deviations from the model.
  task automatic watch(input logic [2:0] st, input logic [1:0] d, input int maxc,
                       output int l, output int b);
    l = 0; b = 0;
    while (state_o == st && l < maxc) begin
      if ({red_o, yellow_o, green_o} !== exp_lamps(st, d, l)) b++;
      if (st != S_OFF && st != S_YB && dir_o !== d) b++;
      l++;
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (state_o !== S_OFF) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_o, S_OFF); end
    vectors++;
    if ({red_o, yellow_o, green_o} !== 9'd0) begin errors++; $display("FAIL reset_lamps: got %b want 0", {red_o, yellow_o, green_o}); end
    vectors++;
    if (dir_o !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d want 0", dir_o); end
    step(); step(); step();
    vectors++;
    if (state_o !== S_OFF || {red_o, yellow_o, green_o} !== 9'd0) begin
      errors++; $display("FAIL reset_idle: state %0d lamps %b, want OFF and dark", state_o, {red_o, yellow_o, green_o});
    end
  endtask

  task automatic test_cycle();
    do_reset();
    send(C_START, 2'd0, 16'd0);
    for (int p = 0; p < 5; p++) begin
      watch(pst[p], 2'd0, 200, len, bad);
      vectors++;
      if (len !== plen[p] || bad !== 0) begin
        errors++; $display("FAIL cycle_dir0_phase%0d: len=%0d lamp_errs=%0d, want len=%0d lamp_errs=0", p, len, bad, plen[p]);
      end
    end
    watch(S_AR, 2'd1, 200, len, bad);
    vectors++;
    if (len !== 4 || bad !== 0) begin errors++; $display("FAIL cycle_clear_dir1: len=%0d lamp_errs=%0d, want 4/0", len, bad); end
    vectors++;
    if (state_o !== S_RY || dir_o !== 2'd1) begin
      errors++; $display("FAIL cycle_next_dir: state %0d dir %0d, want %0d dir 1", state_o, dir_o, S_RY);
    end
  endtask

  task automatic test_set_green();
    int want;
    do_reset();
    send(C_BLINK, 2'd0, 16'd0);
    watch(S_YB, 2'd0, 10, len, bad);
    vectors++;
    if (len !== 10 || bad !== 0) begin errors++; $display("FAIL blink_wave: len=%0d lamp_errs=%0d, want 10/0", len, bad); end
    send(C_SET_G, 2'd1, 16'd7);
    vectors++;
    if (state_o !== S_YB) begin errors++; $display("FAIL set_keeps_blink: got %0d want %0d", state_o, S_YB); end
    send(C_SET_G, 2'd3, 16'd1);
    send(C_START, 2'd0, 16'd0);
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 5; p++) begin
        want = (p == 2 && d == 1) ? 14 : plen[p];
        watch(pst[p], 2'(d), 200, len, bad);
        vectors++;
        if (len !== want || bad !== 0) begin
          errors++; $display("FAIL set_green_dir%0d_phase%0d: len=%0d lamp_errs=%0d, want len=%0d lamp_errs=0", d, p, len, bad, want);
        end
      end
    end
  endtask

  task automatic test_set_ignored();
    do_reset();
    send(C_START, 2'd0, 16'd0);
    watch(S_AR, 2'd0, 200, len, bad);
    watch(S_RY, 2'd0, 200, len, bad);
    watch(S_G, 2'd0, 3, len, bad);
    vectors++;
    if (len !== 3) begin errors++; $display("FAIL ign_green_head: len=%0d want 3", len); end
    send(C_SET_Y, 2'd0, 16'd10);
    vectors++;
    if (state_o !== S_G) begin errors++; $display("FAIL ign_state: got %0d want %0d", state_o, S_G); end
    send(3'd7, 2'd0, 16'd0);
    watch(S_G, 2'd0, 200, len, bad);
    vectors++;
    if (len !== 5 || bad !== 0) begin errors++; $display("FAIL ign_green_tail: len=%0d lamp_errs=%0d, want 5/0", len, bad); end
    watch(S_GB, 2'd0, 200, len, bad);
    watch(S_Y, 2'd0, 200, len, bad);
    vectors++;
    if (len !== 4 || bad !== 0) begin errors++; $display("FAIL ign_yellow: len=%0d lamp_errs=%0d, want 4/0", len, bad); end
  endtask

  task automatic test_off_restart();
    do_reset();
    send(C_START, 2'd0, 16'd0);
    watch(S_AR, 2'd0, 200, len, bad);
    watch(S_RY, 2'd0, 200, len, bad);
    watch(S_G, 2'd0, 200, len, bad);
    watch(S_GB, 2'd0, 3, len, bad);
    send(C_OFF, 2'd0, 16'd0);
    vectors++;
    if (state_o !== S_OFF || {red_o, yellow_o, green_o} !== 9'd0) begin
      errors++; $display("FAIL off_now: state %0d lamps %b, want OFF and dark", state_o, {red_o, yellow_o, green_o});
    end
    watch(S_OFF, 2'd0, 5, len, bad);
    vectors++;
    if (len !== 5 || bad !== 0) begin errors++; $display("FAIL off_hold: len=%0d lamp_errs=%0d, want 5/0", len, bad); end
    send(C_START, 2'd0, 16'd0);
    watch(S_AR, 2'd0, 200, len, bad);
    vectors++;
    if (len !== 4 || bad !== 0) begin errors++; $display("FAIL restart_clear: len=%0d lamp_errs=%0d, want 4/0", len, bad); end
    watch(S_RY, 2'd0, 200, len, bad);
    vectors++;
    if (len !== 2 || bad !== 0) begin errors++; $display("FAIL restart_ry: len=%0d lamp_errs=%0d, want 2/0", len, bad); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(C_START, 2'd0, 16'd0);
    watch(S_AR, 2'd0, 200, len, bad);
    watch(S_RY, 2'd0, 1, len, bad);
    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
    vectors++;
    if (state_o !== S_OFF || {red_o, yellow_o, green_o} !== 9'd0 || dir_o !== 2'd0) begin
      errors++; $display("FAIL reset_mid: state %0d lamps %b dir %0d, want OFF dark dir 0", state_o, {red_o, yellow_o, green_o}, dir_o);
    end
  endtask

  task automatic test_demand();
    do_reset();
    demand_i = 3'b000;
    send(C_START, 2'd0, 16'd0);
    demand_i = 3'b100;
    step();
    demand_i = 3'b000;
    watch(S_AR, 2'd0, 200, len, bad);
    vectors++;
    if (len !== 3 || bad !== 0) begin errors++; $display("FAIL dmd_first_clear: len=%0d lamp_errs=%0d, want 3/0", len, bad); end
    for (int p = 1; p < 5; p++) watch(pst[p], 2'd0, 200, len, bad);
    watch(S_AR, 2'd1, 200, len, bad);
    vectors++;
    if (len !== 4 || bad !== 0) begin errors++; $display("FAIL dmd_clear: len=%0d lamp_errs=%0d, want 4/0", len, bad); end
`ifdef DEMAND_SKIP_EN
    for (int p = 1; p < 5; p++) begin
      watch(pst[p], 2'd2, 200, len, bad);
      vectors++;
      if (len !== plen[p] || bad !== 0) begin
        errors++; $display("FAIL dmd_dir2_phase%0d: len=%0d lamp_errs=%0d, want len=%0d lamp_errs=0", p, len, bad, plen[p]);
      end
    end
    watch(S_AR, 2'd0, 50, len, bad);
    vectors++;
    if (len !== 50 || bad !== 0) begin errors++; $display("FAIL dmd_idle_hold: len=%0d lamp_errs=%0d, want 50/0", len, bad); end
    demand_i = 3'b010;
    step();
    demand_i = 3'b000;
    watch(S_AR, 2'd0, 10, len, bad);
    vectors++;
    if (len !== 1) begin errors++; $display("FAIL dmd_wake: len=%0d want 1", len); end
    vectors++;
    if (state_o !== S_RY || dir_o !== 2'd1) begin
      errors++; $display("FAIL dmd_wake_dir: state %0d dir %0d, want %0d dir 1", state_o, dir_o, S_RY);
    end
`else
    vectors++;
    if (state_o !== S_RY || dir_o !== 2'd1) begin
      errors++; $display("FAIL rotate_ignores_demand: state %0d dir %0d, want %0d dir 1", state_o, dir_o, S_RY);
    end
`endif
  endtask

  task automatic test_saturate();
    do_reset();
    send(C_BLINK, 2'd0, 16'd0);
    send(C_SET_G, 2'd0, 16'd0);
    send(C_SET_G, 2'd1, 16'd40000);
    send(C_START, 2'd0, 16'd0);
    watch(S_AR, 2'd0, 200, len, bad);
    watch(S_RY, 2'd0, 200, len, bad);
    watch(S_G, 2'd0, 200, len, bad);
    vectors++;
    if (len !== 1 || bad !== 0) begin errors++; $display("FAIL sat_zero_green: len=%0d lamp_errs=%0d, want 1/0", len, bad); end
    watch(S_GB, 2'd0, 200, len, bad);
    watch(S_Y, 2'd0, 200, len, bad);
    watch(S_AR, 2'd1, 200, len, bad);
    watch(S_RY, 2'd1, 200, len, bad);
    watch(S_G, 2'd1, 70000, len, bad);
    vectors++;
    if (len !== 65535 || bad !== 0) begin errors++; $display("FAIL sat_max_green: len=%0d lamp_errs=%0d, want 65535/0", len, bad); end
    watch(S_GB, 2'd1, 200, len, bad);
    vectors++;
    if (len !== 8 || bad !== 0) begin errors++; $display("FAIL sat_after_blink: len=%0d lamp_errs=%0d, want 8/0", len, bad); end
  endtask

  initial begin
    pst  = '{S_AR, S_RY, S_G, S_GB, S_Y};
    plen = '{4, 2, 10, 8, 4};
    test_reset();
    test_cycle();
    test_set_green();
    test_set_ignored();
    test_off_restart();
    test_reset_mid();
    test_demand();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
